// File: rtl/commit_pkg.sv
// Shared types and constants for the commit stage.
// Branch results carry {target, fall-through} in the low 16 bits of the slot data.
package commit_pkg;

  localparam int BR_TGT_MSB = 15;
  localparam int BR_TGT_LSB = 8;
  localparam int BR_FT_MSB  = 7;
  localparam int BR_FT_LSB  = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Only the branch-field part of the result is carried; RF data bypasses the struct.
  typedef struct packed {
    logic                  we;
    logic                  we_f;
    logic                  sw;
    logic                  br;
    logic                  pred;
    logic                  act;
    logic [4:0]            addr;
    logic [BR_TGT_MSB:0]   data;
  } slot_t;

  function automatic logic slot_complete(slot_t s);
    return s.we | s.we_f | s.sw | s.br;
  endfunction

  function automatic logic slot_mispredict(slot_t s);
    return s.br && (s.pred != s.act);
  endfunction

endpackage

// File: rtl/commit_store_queue.sv
// Circular FIFO of committed store tags: two in-order push ports, one pop port.
// A second push without the first lands in the first free entry.
module commit_store_queue
  import commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push1,
  input  logic [TAG_W-1:0] tag1,
  input  logic             push2,
  input  logic [TAG_W-1:0] tag2,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] free_count
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr2;
  logic [CNT_W-1:0] count_reg;
  logic [1:0]       n_push;
  logic             do_pop;

  assign n_push     = {1'b0, push1} + {1'b0, push2};
  assign do_pop     = pop && !empty;
  assign wr_ptr2    = wr_ptr_reg + PTR_W'(push1);
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign free_count = CNT_W'(DEPTH) - count_reg;
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push1) mem[wr_ptr_reg] <= tag1;
    if (push2) mem[wr_ptr2]    <= tag2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_push);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(do_pop);
      count_reg  <= count_reg + CNT_W'(n_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order dual retirement from the ROB head with store release, predictor update
// and mispredict flush. Optional counters under COMMIT_STATS_EN.
module commit_unit
  import commit_pkg::*;
#(
  parameter int TAG_W        = 5,
  parameter int DATA_W       = 32,
  parameter int SQ_DEPTH     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  head_tag,
  input  logic              h1_we,
  input  logic              h1_we_f,
  input  logic              h1_sw,
  input  logic              h1_br,
  input  logic              h1_pred,
  input  logic              h1_act,
  input  logic [4:0]        h1_addr,
  input  logic [DATA_W-1:0] h1_data,
  input  logic              h2_we,
  input  logic              h2_we_f,
  input  logic              h2_sw,
  input  logic              h2_br,
  input  logic              h2_pred,
  input  logic              h2_act,
  input  logic [4:0]        h2_addr,
  input  logic [DATA_W-1:0] h2_data,
  output logic [1:0]        pop,
  output logic              rf_we1,
  output logic [4:0]        rf_addr1,
  output logic [DATA_W-1:0] rf_data1,
  output logic              rf_we2,
  output logic [4:0]        rf_addr2,
  output logic [DATA_W-1:0] rf_data2,
  output logic              frf_we1,
  output logic [4:0]        frf_addr1,
  output logic [DATA_W-1:0] frf_data1,
  output logic              frf_we2,
  output logic [4:0]        frf_addr2,
  output logic [DATA_W-1:0] frf_data2,
  output logic              st_valid,
  output logic [TAG_W-1:0]  st_tag,
  input  logic              st_ready,
  output logic              bp_update,
  output logic              bp_taken,
  output logic              bp_mispredict,
  output logic [4:0]        bp_ghr,
  output logic [7:0]        bp_baddr,
  output logic              flush,
  output logic [7:0]        redirect_pc,
`ifdef COMMIT_STATS_EN
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_mispred,
`endif
  output logic              busy
);

  localparam int SQ_CNT_W = $clog2(SQ_DEPTH) + 1;
  localparam int FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  slot_t               s1, s2, br_slot;
  logic                ret1, ret2, br1, mis_retire;
  logic [SQ_CNT_W-1:0] need2;
  logic                sq_full, sq_empty;
  logic [SQ_CNT_W-1:0] sq_free;
  logic [TAG_W-1:0]    sq_head;
  state_t              state_reg, state_next;
  logic [FC_W-1:0]     cnt_reg, cnt_next;
  logic                flush_reg;
  logic [7:0]          redirect_reg, redirect_next;

  assign s1 = '{we: h1_we, we_f: h1_we_f, sw: h1_sw, br: h1_br, pred: h1_pred,
                act: h1_act, addr: h1_addr, data: h1_data[BR_TGT_MSB:0]};
  assign s2 = '{we: h2_we, we_f: h2_we_f, sw: h2_sw, br: h2_br, pred: h2_pred,
                act: h2_act, addr: h2_addr, data: h2_data[BR_TGT_MSB:0]};

  // Room check uses occupancy at the start of the cycle; a same-cycle drain is not credited.
  assign need2 = SQ_CNT_W'(s1.sw) + SQ_CNT_W'(1);
  assign ret1  = !rst && (state_reg == RUN) && slot_complete(s1) && (!s1.sw || !sq_full);
  assign ret2  = ret1 && slot_complete(s2) && !slot_mispredict(s1) && !(s1.br && s2.br)
                 && (!s2.sw || (sq_free >= need2));
  assign pop   = {1'b0, ret1} + {1'b0, ret2};

  assign rf_we1    = ret1 && s1.we;
  assign rf_addr1  = h1_addr;
  assign rf_data1  = h1_data;
  assign rf_we2    = ret2 && s2.we;
  assign rf_addr2  = h2_addr;
  assign rf_data2  = h2_data;
  assign frf_we1   = ret1 && s1.we_f;
  assign frf_addr1 = h1_addr;
  assign frf_data1 = h1_data;
  assign frf_we2   = ret2 && s2.we_f;
  assign frf_addr2 = h2_addr;
  assign frf_data2 = h2_data;

  // At most one of the two retiring slots can be a branch.
  assign br1           = ret1 && s1.br;
  assign br_slot       = br1 ? s1 : s2;
  assign bp_update     = br1 || (ret2 && s2.br);
  assign bp_taken      = bp_update && br_slot.act;
  assign bp_mispredict = bp_update && slot_mispredict(br_slot);
  assign bp_ghr        = bp_update ? br_slot.addr : 5'd0;
  assign bp_baddr      = bp_update ? br_slot.data[BR_TGT_MSB:BR_TGT_LSB] : 8'd0;
  assign mis_retire    = bp_mispredict;
  assign redirect_next = br_slot.act ? br_slot.data[BR_TGT_MSB:BR_TGT_LSB]
                                     : br_slot.data[BR_FT_MSB:BR_FT_LSB];

  commit_store_queue #(
    .DEPTH (SQ_DEPTH),
    .TAG_W (TAG_W)
  ) u_sq (
    .clk        (clk),
    .rst        (rst),
    .push1      (ret1 && s1.sw),
    .tag1       (head_tag),
    .push2      (ret2 && s2.sw),
    .tag2       (head_tag + TAG_W'(1)),
    .pop        (st_ready),
    .head       (sq_head),
    .full       (sq_full),
    .empty      (sq_empty),
    .free_count (sq_free)
  );

  assign st_valid = !sq_empty;
  assign st_tag   = sq_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (mis_retire) begin
          state_next = FLUSH;
          cnt_next   = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_reg == '0) state_next = RUN;
        else               cnt_next   = cnt_reg - FC_W'(1);
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    busy = (state_reg == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_reg    <= 1'b0;
      redirect_reg <= 8'd0;
    end else begin
      flush_reg <= mis_retire;
      if (mis_retire) redirect_reg <= redirect_next;
    end
  end

  assign flush       = flush_reg;
  assign redirect_pc = redirect_reg;

`ifdef COMMIT_STATS_EN
  logic [31:0] stat_retired_reg, stat_mispred_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retired_reg <= '0;
      stat_mispred_reg <= '0;
    end else begin
      stat_retired_reg <= stat_retired_reg + 32'(pop);
      stat_mispred_reg <= stat_mispred_reg + 32'(mis_retire);
    end
  end

  assign stat_retired = stat_retired_reg;
  assign stat_mispred = stat_mispred_reg;
`endif

endmodule

// File: doc/commit_unit.md
# commit_unit

Retirement stage at the head of the reorder buffer. Each cycle it inspects the two oldest ROB entries and retires up to two in order. It drives integer and FP register-file writes, releases committed stores to the data-memory port through a small queue, and updates the branch predictor. On a committed misprediction it raises a pipeline flush with a redirect PC.

## Interface
Parameters:
- TAG_W, 5, ROB tag width (32 entries)
- DATA_W, 32, result width
- SQ_DEPTH, 4, committed-store queue depth (power of 2)
- FLUSH_CYCLES, 2, cycles retirement is held after a flush

Ports:
- Clock and reset: clk is the clock; rst is a synchronous, active-high reset.
- clk  in  1  clock
- rst  in  1  reset
- head_tag  in  TAG_W  ROB read pointer; slot 1 = head_tag, slot 2 = head_tag+1 (mod 32)
- hN_we, hN_we_f, hN_sw, hN_br  in  1 each (N=1,2)  slot done flags: int write, FP write, store, branch
- hN_pred, hN_act  in  1 each  predicted / actual branch direction
- hN_addr  in  5  destination register, or GHR for branches
- hN_data  in  DATA_W  result; for branches [15:8] = target, [7:0] = fall-through
- pop  out  2  entries retired this cycle (0/1/2)
- rf_weN, rf_addrN[4:0], rf_dataN[DATA_W]  out  integer RF write port N
- frf_weN, frf_addrN[4:0], frf_dataN[DATA_W]  out  FP RF write port N
- st_valid  out  1 / st_tag  out  TAG_W / st_ready  in  1  store release handshake
- bp_update, bp_taken, bp_mispredict  out  1; bp_ghr  out  5; bp_baddr  out  8  predictor update
- flush  out  1 / redirect_pc  out  8  front-end redirect
- busy  out  1  high in FLUSH state

## Operation
- Slot complete: any of we, we_f, sw, br is set.
- Slot 1 retires when:
  - state is RUN,
  - slot 1 is complete,
  - and, if slot 1 is a store, the store queue (SQ) is not full.
- Slot 2 retires only when all of the following hold:
  - slot 1 retires,
  - slot 2 is complete,
  - slot 1 is not a mispredicted branch,
  - slot 1 and slot 2 are not both branches,
  - and, if slot 2 is a store, the SQ has room after slot 1's store (if any).
- pop = number of slots retired. RF/FRF write enables are asserted only for retired slots with we / we_f set.
- Store retire: push the slot's tag into the SQ. Two stores may push in the same cycle. st_valid = SQ not empty, st_tag = SQ head; the SQ pops on st_valid && st_ready.
- Branch retire:
  - bp_update=1, bp_taken=act, bp_ghr=addr, bp_baddr=data[15:8], bp_mispredict = pred!=act.
  - At most one branch retires per cycle.
- Misprediction retire:
  - Enter FLUSH.
  - redirect_pc = act ? data[15:8] : data[7:0].
- State machine:
  - RUN -> FLUSH on a mispredict retire.
  - FLUSH holds a down-counter loaded with FLUSH_CYCLES-1; pop=0 and no RF writes while in FLUSH.
  - FLUSH -> RUN when the counter reaches 0.
- Stores already in the SQ continue draining during FLUSH; they are architectural.
- Dual-write hazard: if both retired slots write the same integer register, both ports fire. The RF gives port 2 priority. The block does not suppress port 1.

## Timing
- pop, rf_*, frf_*, bp_*: combinational from head inputs and current state, valid the same cycle. The ROB advances rd_p on the next edge.
- flush, redirect_pc: registered, asserted for exactly 1 cycle, the cycle after the mispredicted branch retires. busy rises in that same cycle.
- SQ push-to-st_valid latency: 1 cycle.
- A full SQ with simultaneous pop and push is not treated as having room; the retire waits one cycle.
- Reset values:
  - pop=0, all write enables 0, st_valid=0, bp_update=0.
  - flush=0, redirect_pc=0, busy=0.
  - SQ empty, state RUN.
- Reset mid-FLUSH or with the SQ non-empty clears everything on the next edge; queued stores are dropped.
- Tag arithmetic wraps mod 2^TAG_W (slot 2 of head 31 is tag 0).

## Configuration
- COMMIT_STATS_EN defined:
  - Adds outputs stat_retired[31:0] (accumulates pop each cycle) and stat_mispred[31:0] (counts mispredict retires).
  - Both counters zeroed by rst and wrap on overflow.
- COMMIT_STATS_EN undefined: these ports and counters do not exist.

## Structure
- Shared package commit_pkg:
  - state enum {RUN, FLUSH};
  - slot struct (we, we_f, sw, br, pred, act, addr, data);
  - BR_TGT_MSB/LSB and BR_FT_MSB/LSB field constants.
- Sub-module commit_store_queue: SQ_DEPTH x TAG_W circular FIFO with 2 push ports, 1 pop port, full/empty/free-count outputs.

## Test plan
- Int writes: slot 1 we, addr=3, data=0x11; slot 2 we, addr=4, data=0x22 -> pop=2, rf_we1/rf_we2 both high with matching addr/data.
- Store backpressure: st_ready=0, retire 5 stores -> the first 4 retire, then pop=0 with slot 1 = store. Raising st_ready drains tags in order and retirement resumes.
- Mispredict: slot 1 br, pred=0, act=1, data=0x2A05; slot 2 complete -> pop=1, bp_mispredict=1. Next cycle flush=1, redirect_pc=0x2A. pop=0 for 2 cycles, then RUN.
- Two branches at the head, both correctly predicted -> pop=1 in the first cycle, pop=1 in the next.
- Wrap: head_tag=31 with both slots complete -> pop=2, and a slot 2 store pushes st_tag=0.
- rst asserted during FLUSH with 3 stores queued -> next cycle busy=0, st_valid=0, flush=0.
